lu_row_store: RTL and testbench

Synthesizable matrix row store that sits on the memory side of the `lu` decomposition core. It answers the core's row-read requests with one-cycle latency, absorbs its row write-backs, and captures the streamed L columns and U rows. A host port loads the input matrix and reads back results. A small controller sequences load, start, run and done.

---
 rtl/lu_row_store.sv | 234 +++++++++++++++++++++++
 tb/tb_lu_row_store.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_row_store.sv
// lu_row_store: matrix row store on the memory side of the lu core.
//
// Holds three SIZE-deep row arrays: M (input and working matrix), and the
// L and U result arrays. The host loads M and reads back any array. The core
// reads M rows with one-cycle latency, writes rows back, and streams L/U
// results. A four-state controller (IDLE/START/RUN/DONE) sequences the run.
//
// Ports
//   clk_i, rst_ni                    clock, async active-low reset
//   start_i, abort_i                 host control
//   host_row_*                       host row load into M (valid/ready)
//   mat_row_read_addr*_i             core read request
//   mat_row_o/_addr_o/_valid_o       core read response (1-cycle latency)
//   mat_row_wr_*                     core write-back into M (valid/ready)
//   l_col_i, u_row_i, result_*       result capture into L/U (valid/ready)
//   lu_start_o, lu_flush_o           control to the core
//   lu_in_ready_i                    core idle indication
//   rd_sel_i, rd_addr_i, rd_valid_i  host readout request (0=M, 1=L, 2=U)
//   rd_data_o, rd_data_valid_o       host readout response (1-cycle latency)
//   busy_o, done_o                   status
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A valid seen while the matching ready is 0 is dropped and has no
// effect; the sender is not required to hold it.

module lu_row_store #(
    parameter int SIZE  = 16,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(SIZE),
    localparam int RW   = SIZE * 2 * WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [RW-1:0] host_row_i,
    input  logic [AW-1:0] host_row_addr_i,
    input  logic          host_row_valid_i,
    output logic          host_row_ready_o,
    input  logic [AW-1:0] mat_row_read_addr_i,
    input  logic          mat_row_read_addr_valid_i,
    output logic [RW-1:0] mat_row_o,
    output logic [AW-1:0] mat_row_addr_o,
    output logic          mat_row_valid_o,
    input  logic [RW-1:0] mat_row_wr_i,
    input  logic [AW-1:0] mat_row_wr_addr_i,
    input  logic          mat_row_wr_valid_i,
    output logic          mat_row_wr_ready_o,
    input  logic [RW-1:0] l_col_i,
    input  logic [RW-1:0] u_row_i,
    input  logic [AW-1:0] result_addr_i,
    input  logic          result_valid_i,
    output logic          result_ready_o,
    output logic          lu_start_o,
    output logic          lu_flush_o,
    input  logic          lu_in_ready_i,
    input  logic [1:0]    rd_sel_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          rd_valid_i,
    output logic [RW-1:0] rd_data_o,
    output logic          rd_data_valid_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            cnt_q, cnt_d;
    logic [SIZE-1:0] loaded_q, loaded_d;
    logic [SIZE-1:0] got_q, got_d, got_set;
    logic            flush_q;

    logic [RW-1:0]   m_mem [SIZE];
    logic [RW-1:0]   l_mem [SIZE];
    logic [RW-1:0]   u_mem [SIZE];

    logic [RW-1:0]   mat_row_q;
    logic [AW-1:0]   mat_row_addr_q;
    logic            mat_row_valid_q;
    logic [RW-1:0]   rd_data_q;
    logic            rd_data_valid_q;
    logic [RW-1:0]   rd_mux;

    logic host_acc, wb_acc, res_acc, abort_act, loaded_full, run_done;

    assign host_acc    = host_row_valid_i & host_row_ready_o;
    assign wb_acc      = mat_row_wr_valid_i & mat_row_wr_ready_o;
    assign res_acc     = result_valid_i & result_ready_o;
    assign abort_act   = abort_i & ((state_q == S_START) | (state_q == S_RUN));
    assign loaded_full = &loaded_q;

    // got including a result accepted this cycle, so DONE is reached on the
    // same edge that completes the set.
    always_comb begin
        got_set = got_q;
        if (res_acc) got_set[result_addr_i] = 1'b1;
    end

    assign run_done = (&got_set) & lu_in_ready_i;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && loaded_full) state_d = S_START;
            end
            S_START: begin
                // Two START cycles: cnt_q is 0 on the first, 1 on the second.
                cnt_d = ~cnt_q;
                if (abort_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 1'b0;
                end else if (cnt_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i)       state_d = S_IDLE;
                else if (run_done) state_d = S_DONE;
            end
            S_DONE: begin
                if (host_row_valid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        host_row_ready_o   = (state_q == S_IDLE) | (state_q == S_DONE);
        lu_start_o         = (state_q == S_START);
        busy_o             = (state_q == S_START) | (state_q == S_RUN);
        done_o             = (state_q == S_DONE);
        mat_row_wr_ready_o = (state_q == S_RUN);
        result_ready_o     = (state_q == S_RUN);
    end

    // ---------------- masks ----------------
    always_comb begin
        loaded_d = loaded_q;
        got_d    = got_set;
        if (host_acc) loaded_d[host_row_addr_i] = 1'b1;
        if (abort_act) begin
            loaded_d = '0;
            got_d    = '0;
        end else if ((state_q == S_IDLE) && start_i && loaded_full) begin
            got_d = '0;
        end else if ((state_q == S_RUN) && run_done) begin
            // Entering DONE: force a full reload before the next start.
            loaded_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            loaded_q <= '0;
            got_q    <= '0;
            flush_q  <= 1'b0;
        end else begin
            loaded_q <= loaded_d;
            got_q    <= got_d;
            flush_q  <= abort_act;
        end
    end

    // ---------------- storage (not reset) ----------------
    // Host loads and core write-backs are exclusive by state.
    always_ff @(posedge clk_i) begin
        if (host_acc)    m_mem[host_row_addr_i]   <= host_row_i;
        else if (wb_acc) m_mem[mat_row_wr_addr_i] <= mat_row_wr_i;
        if (res_acc) begin
            l_mem[result_addr_i] <= l_col_i;
            u_mem[result_addr_i] <= u_row_i;
        end
    end

    // ---------------- registered read ports ----------------
    always_comb begin
        rd_mux = '0;
        unique case (rd_sel_i)
            2'd0:    rd_mux = m_mem[rd_addr_i];
            2'd1:    rd_mux = l_mem[rd_addr_i];
            2'd2:    rd_mux = u_mem[rd_addr_i];
            default: rd_mux = '0;
        endcase
    end

    // Reads sample the arrays before this edge's writes land, so a same-edge
    // collision returns the old row.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mat_row_q       <= '0;
            mat_row_addr_q  <= '0;
            mat_row_valid_q <= 1'b0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
        end else begin
            mat_row_valid_q <= mat_row_read_addr_valid_i;
            if (mat_row_read_addr_valid_i) begin
                mat_row_q      <= m_mem[mat_row_read_addr_i];
                mat_row_addr_q <= mat_row_read_addr_i;
            end
            rd_data_valid_q <= rd_valid_i;
            if (rd_valid_i) rd_data_q <= rd_mux;
        end
    end

    assign mat_row_o       = mat_row_q;
    assign mat_row_addr_o  = mat_row_addr_q;
    assign mat_row_valid_o = mat_row_valid_q;
    assign rd_data_o       = rd_data_q;
    assign rd_data_valid_o = rd_data_valid_q;
    assign lu_flush_o      = flush_q;

endmodule

// File: tb/tb_lu_row_store.sv
// Directed bench for lu_row_store. Inputs change 1 time unit after a rising
// edge; outputs are checked at that same point, i.e. reflecting that edge.

module tb_lu_row_store;
    localparam int SIZE  = 16;
    localparam int WIDTH = 64;
    localparam int AW    = 4;
    localparam int EW    = 2 * WIDTH;
    localparam int RW    = SIZE * EW;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          start_i = 1'b0, abort_i = 1'b0;
    logic [RW-1:0] host_row_i = '0;
    logic [AW-1:0] host_row_addr_i = '0;
    logic          host_row_valid_i = 1'b0;
    logic          host_row_ready_o;
    logic [AW-1:0] mat_row_read_addr_i = '0;
    logic          mat_row_read_addr_valid_i = 1'b0;
    logic [RW-1:0] mat_row_o;
    logic [AW-1:0] mat_row_addr_o;
    logic          mat_row_valid_o;
    logic [RW-1:0] mat_row_wr_i = '0;
    logic [AW-1:0] mat_row_wr_addr_i = '0;
    logic          mat_row_wr_valid_i = 1'b0;
    logic          mat_row_wr_ready_o;
    logic [RW-1:0] l_col_i = '0, u_row_i = '0;
    logic [AW-1:0] result_addr_i = '0;
    logic          result_valid_i = 1'b0;
    logic          result_ready_o;
    logic          lu_start_o, lu_flush_o;
    logic          lu_in_ready_i = 1'b0;
    logic [1:0]    rd_sel_i = '0;
    logic [AW-1:0] rd_addr_i = '0;
    logic          rd_valid_i = 1'b0;
    logic [RW-1:0] rd_data_o;
    logic          rd_data_valid_o;
    logic          busy_o, done_o;

    int n_checks = 0;
    int n_pass   = 0;

    lu_row_store #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .host_row_i(host_row_i), .host_row_addr_i(host_row_addr_i),
        .host_row_valid_i(host_row_valid_i), .host_row_ready_o(host_row_ready_o),
        .mat_row_read_addr_i(mat_row_read_addr_i),
        .mat_row_read_addr_valid_i(mat_row_read_addr_valid_i),
        .mat_row_o(mat_row_o), .mat_row_addr_o(mat_row_addr_o),
        .mat_row_valid_o(mat_row_valid_o),
        .mat_row_wr_i(mat_row_wr_i), .mat_row_wr_addr_i(mat_row_wr_addr_i),
        .mat_row_wr_valid_i(mat_row_wr_valid_i), .mat_row_wr_ready_o(mat_row_wr_ready_o),
        .l_col_i(l_col_i), .u_row_i(u_row_i), .result_addr_i(result_addr_i),
        .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
        .lu_start_o(lu_start_o), .lu_flush_o(lu_flush_o), .lu_in_ready_i(lu_in_ready_i),
        .rd_sel_i(rd_sel_i), .rd_addr_i(rd_addr_i), .rd_valid_i(rd_valid_i),
        .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- helpers ----------------
    // Row i, element j = {imag = -i, real = i + j} as IEEE doubles.
    function automatic logic [RW-1:0] mk_row(input int i);
        logic [RW-1:0] r;
        r = '0;
        for (int j = 0; j < SIZE; j++)
            r[j*EW +: EW] = {$realtobits(-real'(i)), $realtobits(real'(i + j))};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_row(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        int bad;
        bad = 0;
        for (int j = SIZE - 1; j >= 0; j--)
            if (obs[j*EW +: EW] !== exp[j*EW +: EW]) bad = j;
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: elem %0d observed %h expected %h", tag, bad,
                    obs[bad*EW +: EW], exp[bad*EW +: EW]);
    endtask

    task automatic load_row(input int a, input logic [RW-1:0] r);
        host_row_i       = r;
        host_row_addr_i  = AW'(a);
        host_row_valid_i = 1'b1;
        tick();
        host_row_valid_i = 1'b0;
    endtask

    task automatic send_result(input int a, input logic [RW-1:0] l, input logic [RW-1:0] u);
        l_col_i        = l;
        u_row_i        = u;
        result_addr_i  = AW'(a);
        result_valid_i = 1'b1;
        tick();
        result_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic readout(input logic [1:0] sel, input int a);
        rd_sel_i   = sel;
        rd_addr_i  = AW'(a);
        rd_valid_i = 1'b1;
        tick();
        rd_valid_i = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] e53;

        // Reset values
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_host_ready", host_row_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_lu_start", lu_start_o, 0);
        chk("rst_lu_flush", lu_flush_o, 0);
        chk("rst_mat_valid", mat_row_valid_o, 0);
        chk("rst_wr_ready", mat_row_wr_ready_o, 0);
        chk("rst_res_ready", result_ready_o, 0);
        chk("rst_rd_valid", rd_data_valid_o, 0);
        chk_row("rst_mat_row", mat_row_o, '0);
        chk_row("rst_rd_data", rd_data_o, '0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Load rows 0..14 only; start must be ignored
        for (int i = 0; i < SIZE - 1; i++) load_row(i, mk_row(i));
        pulse_start();
        chk("gate_lu_start", lu_start_o, 0);
        chk("gate_busy", busy_o, 0);
        tick();
        chk("gate_lu_start2", lu_start_o, 0);

        // 16th row, then core read of row 5
        load_row(SIZE - 1, mk_row(SIZE - 1));
        mat_row_read_addr_i       = 4'd5;
        mat_row_read_addr_valid_i = 1'b1;
        tick();
        mat_row_read_addr_valid_i = 1'b0;
        e53 = mat_row_o[3*EW +: EW];
        chk("rd5_valid", mat_row_valid_o, 1);
        chk("rd5_addr", mat_row_addr_o, 5);
        n_checks++;
        assert (e53 === 128'hC014000000000000_4020000000000000) n_pass++;
        else $error("FAIL rd5_elem3: observed %h expected %h", e53,
                    128'hC014000000000000_4020000000000000);
        chk_row("rd5_row", mat_row_o, mk_row(5));
        tick();
        chk("rd_idle_valid", mat_row_valid_o, 0);
        chk_row("rd_hold", mat_row_o, mk_row(5));

        // Start: lu_start_o high for exactly two cycles
        pulse_start();
        chk("start_c1", lu_start_o, 1);
        chk("start_busy", busy_o, 1);
        tick();
        chk("start_c2", lu_start_o, 1);
        tick();
        chk("start_c3", lu_start_o, 0);
        chk("run_busy", busy_o, 1);
        chk("run_wr_ready", mat_row_wr_ready_o, 1);
        chk("run_res_ready", result_ready_o, 1);
        chk("run_host_ready", host_row_ready_o, 0);

        // Collision: write-back and read of row 3 on the same edge
        mat_row_wr_i              = ~mk_row(3);
        mat_row_wr_addr_i         = 4'd3;
        mat_row_wr_valid_i        = 1'b1;
        mat_row_read_addr_i       = 4'd3;
        mat_row_read_addr_valid_i = 1'b1;
        tick();
        mat_row_wr_valid_i = 1'b0;
        chk_row("coll_old", mat_row_o, mk_row(3));
        chk("coll_addr", mat_row_addr_o, 3);
        tick();
        mat_row_read_addr_valid_i = 1'b0;
        chk_row("coll_new", mat_row_o, ~mk_row(3));

        // Results 0..15, then addr 7 again; core not yet idle
        for (int a = 0; a < SIZE; a++) send_result(a, mk_row(a + 16), mk_row(a + 32));
        chk("full_not_idle_done", done_o, 0);
        rd_sel_i   = 2'd1;
        rd_addr_i  = 4'd7;
        rd_valid_i = 1'b1;
        send_result(7, mk_row(60), mk_row(61));
        rd_valid_i = 1'b0;
        chk_row("rdL7_collision_old", rd_data_o, mk_row(23));
        chk("rdL7_valid", rd_data_valid_o, 1);
        chk("wait_done", done_o, 0);
        chk("wait_busy", busy_o, 1);
        lu_in_ready_i = 1'b1;
        tick();
        lu_in_ready_i = 1'b0;
        chk("done_rise", done_o, 1);
        chk("done_busy", busy_o, 0);

        // Readout of results and matrix
        readout(2'd1, 7);
        chk_row("rdL7_second", rd_data_o, mk_row(60));
        readout(2'd2, 7);
        chk_row("rdU7_second", rd_data_o, mk_row(61));
        readout(2'd1, 2);
        chk_row("rdL2", rd_data_o, mk_row(18));
        readout(2'd0, 3);
        chk_row("rdM3", rd_data_o, ~mk_row(3));
        readout(2'd3, 3);
        chk_row("rd_reserved", rd_data_o, '0);
        tick();
        chk("rd_valid_drop", rd_data_valid_o, 0);

        // DONE: start ignored, a load returns to IDLE with loaded cleared
        pulse_start();
        chk("done_start_ignored", lu_start_o, 0);
        chk("done_held", done_o, 1);
        load_row(0, mk_row(0));
        chk("load_to_idle_done", done_o, 0);
        chk("load_to_idle_ready", host_row_ready_o, 1);
        pulse_start();
        chk("reload_required", lu_start_o, 0);

        // Abort in RUN after four results
        for (int i = 1; i < SIZE; i++) load_row(i, mk_row(i));
        pulse_start();
        tick();
        tick();
        chk("abort_pre_busy", busy_o, 1);
        for (int a = 0; a < 4; a++) send_result(a, mk_row(a), mk_row(a));
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_flush", lu_flush_o, 1);
        chk("abort_busy", busy_o, 0);
        chk("abort_idle_ready", host_row_ready_o, 1);
        tick();
        chk("abort_flush_1cyc", lu_flush_o, 0);
        pulse_start();
        chk("abort_start_ignored", lu_start_o, 0);
        for (int i = 0; i < SIZE; i++) load_row(i, mk_row(i));
        pulse_start();
        chk("abort_restart", lu_start_o, 1);
        tick();
        tick();

        // Reset mid-RUN with a read response outstanding
        mat_row_read_addr_i       = 4'd2;
        mat_row_read_addr_valid_i = 1'b1;
        tick();
        mat_row_read_addr_valid_i = 1'b0;
        chk("pre_rst_valid", mat_row_valid_o, 1);
        chk("pre_rst_busy", busy_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_busy", busy_o, 0);
        chk("async_rst_valid", mat_row_valid_o, 0);
        chk("async_rst_ready", host_row_ready_o, 1);
        chk("async_rst_res_ready", result_ready_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
